// File: rtl/button_sense.sv
// button_sense: debounced push-button input stage.
// Synchronises a raw button pin, qualifies level changes with a DB-cycle
// debounce counter and produces a clean level, press/release pulses, a press
// counter and (optionally) a long-press pulse.
// Optional feature macro: BUTTON_SENSE_LONG_PRESS_EN enables the long-press
// counter and long_o; without it long_o is tied low and LONG_MS is unused.
module button_sense #(
    parameter int FREQ        = 25_000_000,
    parameter int DEBOUNCE_US = 10_000,
    parameter int LONG_MS     = 1000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       btn_i,
    output logic       pressed_o,
    output logic       press_o,
    output logic       release_o,
    output logic       long_o,
    output logic [7:0] count_o
);

    localparam int DB = FREQ / 1_000_000 * DEBOUNCE_US;
    localparam int LP = FREQ / 1000 * LONG_MS;
    localparam int CW = $clog2(DB + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB - 1);
    // Pin level seen while the button is released.
    localparam logic IDLE_LEVEL = ACTIVE_LOW;

    // Catch impossible parameter sets at elaboration time.
    if (DB < 1 || LP <= DB) begin : g_bad_params
        $error("button_sense: parameters must give DB >= 1 and LP > DB");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        DOWN,
        RELEASE_WAIT
    } state_t;

    logic          sync1_reg, sync2_reg;
    logic          p;
    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          pressed_reg, pressed_next;
    logic          press_reg, press_next;
    logic          release_reg, release_next;
    logic [7:0]    count_reg, count_next;
    logic          lp_clear;

    // Two-flop synchroniser, reset to the released pin level so a button held
    // through reset is seen as a fresh press afterwards.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_reg <= IDLE_LEVEL;
            sync2_reg <= IDLE_LEVEL;
        end else begin
            sync1_reg <= btn_i;
            sync2_reg <= sync1_reg;
        end
    end

    // Normalised level: 1 = pressed regardless of pin polarity.
    assign p = sync2_reg ^ IDLE_LEVEL;

    // Debounce FSM, counter and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            pressed_reg <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            count_reg   <= 8'd0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pressed_reg <= pressed_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            count_reg   <= count_next;
        end
    end

    // Next-state logic; pulses are computed here and registered above.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        pressed_next = pressed_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        count_next   = count_reg;
        lp_clear     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (p) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!p) begin
                    state_next = IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next   = DOWN;
                    press_next   = 1'b1;
                    pressed_next = 1'b1;
                    count_next   = count_reg + 8'd1;
                    lp_clear     = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DOWN: begin
                if (!p) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (p) begin
                    state_next = DOWN;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                    pressed_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pressed_o = pressed_reg;
    assign press_o   = press_reg;
    assign release_o = release_reg;
    assign count_o   = count_reg;

`ifdef BUTTON_SENSE_LONG_PRESS_EN
    localparam int LW = $clog2(LP + 1);
    localparam logic [LW-1:0] LCNT_LAST = LW'(LP - 1);
    localparam logic [LW-1:0] LCNT_FIRE = LW'(LP - 2);

    logic [LW-1:0] lcnt_reg, lcnt_next;
    logic          fired_reg, fired_next;
    logic          long_reg, long_next;

    // Long-press counter, fired flag and pulse register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lcnt_reg  <= '0;
            fired_reg <= 1'b0;
            long_reg  <= 1'b0;
        end else begin
            lcnt_reg  <= lcnt_next;
            fired_reg <= fired_next;
            long_reg  <= long_next;
        end
    end

    // Count held time (an unqualified release keeps counting); pulse on the
    // edge where the count reaches LP-1, then saturate.
    always_comb begin
        lcnt_next  = lcnt_reg;
        fired_next = fired_reg;
        long_next  = 1'b0;
        if (lp_clear) begin
            lcnt_next  = '0;
            fired_next = 1'b0;
        end else if ((state_reg == DOWN || state_reg == RELEASE_WAIT) &&
                     lcnt_reg != LCNT_LAST) begin
            lcnt_next = lcnt_reg + 1'b1;
            if (lcnt_reg == LCNT_FIRE && !fired_reg) begin
                long_next  = 1'b1;
                fired_next = 1'b1;
            end
        end
    end

    assign long_o = long_reg;
`else
    assign long_o = 1'b0;
`endif

endmodule

// File: tb/tb_button_sense.sv
// tb_button_sense: directed bench for button_sense with DB=10, LP=1000,
// active-low pin. Pulse positions are counted in clock edges after btn_i
// changes (edge 0 is the first rising edge after the change).
module tb_button_sense;

    logic       clk;
    logic       rst_ni;
    logic       btn_i;
    logic       pressed_o;
    logic       press_o;
    logic       release_o;
    logic       long_o;
    logic [7:0] count_o;

    int         n_vec;
    int         n_err;
    logic [7:0] exp_count;

`ifdef BUTTON_SENSE_LONG_PRESS_EN
    localparam int LONG_AT = 1011;
`else
    localparam int LONG_AT = -1;
`endif

    button_sense #(
        .FREQ        (1_000_000),
        .DEBOUNCE_US (10),
        .LONG_MS     (1),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .btn_i     (btn_i),
        .pressed_o (pressed_o),
        .press_o   (press_o),
        .release_o (release_o),
        .long_o    (long_o),
        .count_o   (count_o)
    );

    // 100 MHz-style bench clock; absolute period is irrelevant to the DUT.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step n edges, checking each pulse output against its expected edge (-1 = never).
    task automatic watch(input string name, input int n, input int p_at, input int r_at, input int l_at);
        for (int j = 0; j < n; j++) begin
            step();
            check($sformatf("%s press_o @%0d", name, j), 32'(press_o), 32'(j == p_at));
            check($sformatf("%s release_o @%0d", name, j), 32'(release_o), 32'(j == r_at));
            check($sformatf("%s long_o @%0d", name, j), 32'(long_o), 32'(j == l_at));
        end
    endtask

    task automatic check_level(input string name, input logic exp_pressed);
        check({name, " pressed_o"}, 32'(pressed_o), 32'(exp_pressed));
        check({name, " count_o"}, 32'(count_o), 32'(exp_count));
    endtask

    initial begin
        clk       = 1'b0;
        rst_ni    = 1'b0;
        btn_i     = 1'b1;
        n_vec     = 0;
        n_err     = 0;
        exp_count = 8'd0;

        // Reset, then 50 idle cycles with everything low.
        repeat (3) step();
        check("reset_hold outputs", 32'({pressed_o, press_o, release_o, long_o, count_o}), 32'd0);
        rst_ni = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            check($sformatf("idle outputs @%0d", i),
                  32'({pressed_o, press_o, release_o, long_o, count_o}), 32'd0);
        end

        // Clean first press and release.
        btn_i = 1'b0;
        watch("first_press", 20, 12, -1, -1);
        exp_count = exp_count + 8'd1;
        check_level("first_press", 1'b1);
        btn_i = 1'b1;
        watch("first_release", 20, -1, 12, -1);
        check_level("first_release", 1'b0);

        // 9-cycle glitch on a released button is rejected.
        btn_i = 1'b0;
        watch("glitch_low", 9, -1, -1, -1);
        btn_i = 1'b1;
        watch("glitch_after", 30, -1, -1, -1);
        check_level("glitch", 1'b0);

        // Bounce every 3 cycles, settling low on the 13th toggle.
        for (int t = 0; t < 13; t++) begin
            btn_i = ~btn_i;
            if (t < 12) watch($sformatf("bounce%0d", t), 3, -1, -1, -1);
        end
        watch("bounce_settle", 20, 12, -1, -1);
        exp_count = exp_count + 8'd1;
        check_level("bounce_press", 1'b1);
        btn_i = 1'b1;
        watch("bounce_release", 20, -1, 12, -1);
        check_level("bounce_release", 1'b0);

        // Long hold: long_o once at edge 1011 when the feature is built in.
        btn_i = 1'b0;
        watch("long_hold", 1200, 12, -1, LONG_AT);
        exp_count = exp_count + 8'd1;
        check_level("long_hold", 1'b1);
        btn_i = 1'b1;
        watch("long_release", 20, -1, 12, -1);
        check_level("long_release", 1'b0);

        // Reset while qualifying a press (cnt=5 after edge 7).
        btn_i = 1'b0;
        watch("abort_wait", 8, -1, -1, -1);
        rst_ni = 1'b0;
        step();
        check("abort_next outputs", 32'({pressed_o, press_o, release_o, long_o, count_o}), 32'd0);
        step();
        check("abort_hold outputs", 32'({pressed_o, press_o, release_o, long_o, count_o}), 32'd0);
        rst_ni    = 1'b1;
        exp_count = 8'd0;
        watch("requalify", 20, 12, -1, -1);
        exp_count = exp_count + 8'd1;
        check_level("requalify", 1'b1);
        btn_i = 1'b1;
        watch("requalify_release", 20, -1, 12, -1);
        check_level("requalify_release", 1'b0);

        // 256 clean presses: counter passes through 0 and returns to 1.
        for (int i = 0; i < 256; i++) begin
            btn_i = 1'b0;
            watch($sformatf("wrap_press%0d", i), 14, 12, -1, -1);
            exp_count = exp_count + 8'd1;
            check_level($sformatf("wrap_press%0d", i), 1'b1);
            btn_i = 1'b1;
            watch($sformatf("wrap_release%0d", i), 14, -1, 12, -1);
        end
        check("wrap_final count_o", 32'(count_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
